rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters: the in-order pipeline writeback (WB) and a long-latency multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO and keeps a busy-register scoreboard for results still in flight.
- Generates the decode-stage stall for RAW and WAW hazards against in-flight results, plus a starvation stall.
- Sits between the WB/MDU stages and the register file write inputs (wren/addr/data).

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a pending MDU result may lose the port before a starvation stall is raised.

Ports:
- i_clk  in  1  clock (single clock domain).
- i_rst_n  in  1  synchronous, active-low reset.
- i_wb_valid  in  1  pipeline WB write request.
- i_wb_addr  in  5  WB destination register.
- i_wb_data  in  32  WB write data.
- i_mdu_valid  in  1  MDU result valid.
- o_mdu_ready  out  1  FIFO can accept an MDU result.
- i_mdu_addr  in  5  MDU destination register.
- i_mdu_data  in  32  MDU result.
- i_issue_valid  in  1  MDU op issued this cycle (from decode).
- i_issue_addr  in  5  destination of the issued MDU op.
- i_rs1_addr  in  5  decode-stage source 1.
- i_rs2_addr  in  5  decode-stage source 2.
- i_dst_addr  in  5  decode-stage destination.
- o_stall  out  1  freeze fetch/decode.
- o_rd_wren  out  1  register file write enable.
- o_rd_addr  out  5  register file write address.
- o_rd_data  out  32  register file write data.
- o_busy_mask  out  32  scoreboard (bit i = register xi pending; bit 0 always 0).

Behaviour:
- Reset: synchronous, active-low. While i_rst_n=0:
  - FIFO is emptied, busy_mask is cleared, starve_cnt is cleared.
  - o_rd_wren=0, o_mdu_ready=0, o_stall=0, o_busy_mask=0; o_rd_addr/o_rd_data=0.
  - Asserting reset mid-operation discards all buffered results with no write.
- Write-port arbitration (combinational, same cycle, so the register file captures on that cycle's negedge):
  - WB request active = i_wb_valid && i_wb_addr!=0. If active, WB owns the port: o_rd_wren=1, o_rd_addr/o_rd_data = WB.
  - Otherwise, if the FIFO is non-empty: the head is driven with o_rd_wren=1 and popped at the next posedge.
  - Otherwise o_rd_wren=0 and addr/data=0.
  - WB always has priority because the pipeline cannot hold WB.
- MDU handshake:
  - o_mdu_ready = !full.
  - Push on the posedge where i_mdu_valid && o_mdu_ready. Results with i_mdu_addr=0 are accepted and dropped (not stored).
  - i_mdu_valid/addr/data must stay stable until accepted.
  - Latency: push at edge N -> earliest write in cycle N+1.
  - Simultaneous push and pop when full: not permitted (ready=0). Push and pop in the same cycle when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - busy[a] is set at the posedge with i_issue_valid && i_issue_addr=a!=0.
  - busy[a] is cleared at the posedge on which a FIFO entry with address a is written.
  - Set and clear of the same address in the same cycle: set wins.
- o_stall (combinational) = busy[i_rs1_addr] | busy[i_rs2_addr] | busy[i_dst_addr] | starve.
  - Addr 0 never stalls.
  - Busy clears one cycle after the write, so hazard stalls are conservative and there is no bypass.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and WB owns the port; it saturates at STARVE_LIMIT.
  - starve_cnt clears on any pop or when the FIFO is empty.
  - starve = (starve_cnt==STARVE_LIMIT). The resulting stall drains the pipeline until WB idles and the FIFO head wins.

Test Plan:
1. Reset held 2 cycles with FIFO holding x5 -> o_rd_wren=0, o_busy_mask=0, o_mdu_ready=0 during reset; after release, ready=1 and no write to x5 ever occurs.
2. Issue MDU op to x7; decode rs1=7 -> o_stall=1. MDU returns x7=0xDEADBEEF with WB idle -> write at cycle N+1; busy[7] clears next edge; o_stall drops.
3. WB x3=0x11 and a pending FIFO head x9=0x22 in the same cycle -> WB x3 written first, x9 written the following cycle.
4. Fill FIFO with DEPTH results while WB is busy every cycle -> o_mdu_ready=0 when full; after STARVE_LIMIT=4 cycles o_stall=1; when WB idles, entries drain in order and wrap correctly.
5. Issue x4 on the same cycle a FIFO entry for x4 is written -> busy[4] remains 1.
6. WB to x0 and MDU result to x0 -> no o_rd_wren, busy_mask unchanged, x0 MDU result is accepted and dropped.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between pipeline
// writeback (always wins) and a buffered multiply/divide result stream.
// Also tracks in-flight MDU destinations and raises the decode stall for
// hazards against them or when buffered results have starved too long.
module rf_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_valid,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   input  logic        i_mdu_valid,
   output logic        o_mdu_ready,
   input  logic [4:0]  i_mdu_addr,
   input  logic [31:0] i_mdu_data,
   input  logic        i_issue_valid,
   input  logic [4:0]  i_issue_addr,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   input  logic [4:0]  i_dst_addr,
   output logic        o_stall,
   output logic        o_rd_wren,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic [31:0] o_busy_mask
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_addr [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   busy;
   logic [31:0]   busy_next;
   logic [SW-1:0] starve_cnt;

   logic full;
   logic empty;
   logic wb_active;
   logic push;
   logic pop;
   logic starve;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign wb_active = i_wb_valid && (i_wb_addr != 5'd0);
   // Results for x0 are acknowledged but never stored.
   assign push      = i_mdu_valid && !full && (i_mdu_addr != 5'd0);
   // The FIFO head only gets the port when writeback leaves it free.
   assign pop       = !wb_active && !empty;
   assign starve    = (starve_cnt == SW'(STARVE_LIMIT));

   // FIFO storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && push) begin
         fifo_addr[wr_ptr] <= i_mdu_addr;
         fifo_data[wr_ptr] <= i_mdu_data;
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Next scoreboard value: clear the register being written from the FIFO, then let a new issue set win.
   always_comb begin
      busy_next = busy;
      if (pop) busy_next[fifo_addr[rd_ptr]] = 1'b0;
      if (i_issue_valid && (i_issue_addr != 5'd0)) busy_next[i_issue_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register of destinations with results still in flight.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) busy <= '0;
      else          busy <= busy_next;
   end

   // Count cycles a waiting FIFO head loses to writeback, saturating at the limit.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || empty || pop) starve_cnt <= '0;
      else if (!starve)             starve_cnt <= starve_cnt + SW'(1);
   end

   // Write port mux plus handshake and stall outputs, all forced quiet during reset.
   always_comb begin
      o_rd_wren   = 1'b0;
      o_rd_addr   = 5'd0;
      o_rd_data   = 32'd0;
      o_mdu_ready = i_rst_n && !full;
      o_busy_mask = i_rst_n ? busy : 32'd0;
      o_stall     = i_rst_n && (busy[i_rs1_addr] || busy[i_rs2_addr] ||
                                busy[i_dst_addr] || starve);
      if (i_rst_n) begin
         if (wb_active) begin
            o_rd_wren = 1'b1;
            o_rd_addr = i_wb_addr;
            o_rd_data = i_wb_data;
         end else if (!empty) begin
            o_rd_wren = 1'b1;
            o_rd_addr = fifo_addr[rd_ptr];
            o_rd_data = fifo_data[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios followed by random traffic; a queue
// based reference model predicts each cycle's outputs, and an independent
// monitor compares them against the arbiter on the falling edge.
module tb_rf_wb_arbiter;

   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   typedef struct {
      logic        rst_n;
      logic        wb_valid;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        issue_valid;
      logic [4:0]  issue_addr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  dst;
   } stim_t;

   typedef struct {
      logic        wren;
      logic        stall;
      logic        ready;
      logic [31:0] busy;
   } status_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        mdu_valid = 1'b0;
   logic        mdu_ready;
   logic [4:0]  mdu_addr = '0;
   logic [31:0] mdu_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic [4:0]  dst_addr = '0;
   logic        stall;
   logic        rd_wren;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] busy_mask;

   int n_checks = 0;
   int n_pass   = 0;

   status_t status_q[$];
   wr_t     write_q[$];

   // Reference model state: buffered results in order, pending registers, starvation count.
   wr_t         mq[$];
   logic [31:0] m_busy   = '0;
   int          m_starve = 0;
   logic        last_ready = 1'b0;

   // Outstanding MDU result, held stable until the model says it was accepted.
   logic        pend_valid = 1'b0;
   logic [4:0]  pend_addr  = '0;
   logic [31:0] pend_data  = '0;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wb_valid    (wb_valid),
      .i_wb_addr     (wb_addr),
      .i_wb_data     (wb_data),
      .i_mdu_valid   (mdu_valid),
      .o_mdu_ready   (mdu_ready),
      .i_mdu_addr    (mdu_addr),
      .i_mdu_data    (mdu_data),
      .i_issue_valid (issue_valid),
      .i_issue_addr  (issue_addr),
      .i_rs1_addr    (rs1_addr),
      .i_rs2_addr    (rs2_addr),
      .i_dst_addr    (dst_addr),
      .o_stall       (stall),
      .o_rd_wren     (rd_wren),
      .o_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .o_busy_mask   (busy_mask)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rst_n = 1'b1; s.wb_valid = 1'b0; s.wb_addr = '0; s.wb_data = '0;
      s.issue_valid = 1'b0; s.issue_addr = '0;
      s.rs1 = '0; s.rs2 = '0; s.dst = '0;
      return s;
   endfunction

   task automatic queueMdu(input logic [4:0] a, input logic [31:0] d);
      pend_valid = 1'b1;
      pend_addr  = a;
      pend_data  = d;
   endtask

   // Drive one cycle, predict its outputs from the model, then advance the model.
   task automatic applyStimulus(input stim_t s);
      status_t st;
      wr_t     w;
      bit      wb_act;
      bit      popped;
      @(posedge clk);
      #1;
      rst_n = s.rst_n; wb_valid = s.wb_valid; wb_addr = s.wb_addr; wb_data = s.wb_data;
      mdu_valid = pend_valid; mdu_addr = pend_addr; mdu_data = pend_data;
      issue_valid = s.issue_valid; issue_addr = s.issue_addr;
      rs1_addr = s.rs1; rs2_addr = s.rs2; dst_addr = s.dst;
      if (!s.rst_n) begin
         st.wren = 1'b0; st.stall = 1'b0; st.ready = 1'b0; st.busy = '0;
         status_q.push_back(st);
         mq.delete();
         m_busy = '0;
         m_starve = 0;
         last_ready = 1'b0;
      end else begin
         wb_act   = s.wb_valid && (s.wb_addr != 0);
         popped   = !wb_act && (mq.size() > 0);
         st.wren  = wb_act || popped;
         st.ready = (mq.size() < DEPTH);
         st.busy  = m_busy;
         st.stall = m_busy[s.rs1] | m_busy[s.rs2] | m_busy[s.dst] | (m_starve == STARVE_LIMIT);
         status_q.push_back(st);
         if (wb_act) begin
            w.addr = s.wb_addr; w.data = s.wb_data;
            write_q.push_back(w);
         end else if (popped) begin
            write_q.push_back(mq[0]);
         end
         if (mq.size() == 0 || popped) m_starve = 0;
         else if (m_starve < STARVE_LIMIT) m_starve++;
         if (popped) begin
            m_busy[mq[0].addr] = 1'b0;
            void'(mq.pop_front());
         end
         if (s.issue_valid && s.issue_addr != 0) m_busy[s.issue_addr] = 1'b1;
         if (pend_valid && st.ready && pend_addr != 0) begin
            w.addr = pend_addr; w.data = pend_data;
            mq.push_back(w);
         end
         last_ready = st.ready;
      end
      if (pend_valid && last_ready) pend_valid = 1'b0;
   endtask

   // Monitor: compare status every stimulated cycle and each write the arbiter presents.
   initial begin
      status_t st;
      wr_t     w;
      forever begin
         @(negedge clk);
         if (status_q.size() > 0) begin
            st = status_q.pop_front();
            checkOutput("rd_wren", {31'd0, rd_wren}, {31'd0, st.wren});
            checkOutput("stall", {31'd0, stall}, {31'd0, st.stall});
            checkOutput("mdu_ready", {31'd0, mdu_ready}, {31'd0, st.ready});
            checkOutput("busy_mask", busy_mask, st.busy);
         end
         if (rd_wren === 1'b1) begin
            if (write_q.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL write_unexpected: got write x%0d=0x%08h, expected no write", rd_addr, rd_data);
            end else begin
               w = write_q.pop_front();
               checkOutput("rd_addr", {27'd0, rd_addr}, {27'd0, w.addr});
               checkOutput("rd_data", rd_data, w.data);
            end
         end
      end
   end

   initial begin
      stim_t s;
      // Reset, then buffer x5 behind a WB write and reset again to discard it.
      s = idle(); s.rst_n = 1'b0;
      applyStimulus(s); applyStimulus(s);
      queueMdu(5'd5, 32'h0000_0055);
      s = idle(); s.wb_valid = 1'b1; s.wb_addr = 5'd1; s.wb_data = 32'h1;
      applyStimulus(s);
      s = idle(); s.rst_n = 1'b0;
      applyStimulus(s); applyStimulus(s);
      for (int i = 0; i < 3; i++) applyStimulus(idle());

      // RAW hazard on x7 resolved by an MDU result.
      s = idle(); s.issue_valid = 1'b1; s.issue_addr = 5'd7;
      applyStimulus(s);
      queueMdu(5'd7, 32'hDEAD_BEEF);
      s = idle(); s.rs1 = 5'd7;
      for (int i = 0; i < 4; i++) applyStimulus(s);

      // WB and a buffered x9 collide: WB first, x9 next cycle.
      queueMdu(5'd9, 32'h22);
      applyStimulus(idle());
      s = idle(); s.wb_valid = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'h11;
      applyStimulus(s);
      applyStimulus(idle());

      // Fill the FIFO under constant WB traffic, starve, then drain; twice for pointer wrap.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) begin
            if (!pend_valid) queueMdu(5'(10 + i), 32'hA000_0000 + 32'(r * 16 + i));
            s = idle(); s.wb_valid = 1'b1; s.wb_addr = 5'(1 + i); s.wb_data = 32'hB000_0000 + 32'(i);
            applyStimulus(s);
         end
         for (int i = 0; i < 6; i++) applyStimulus(idle());
      end

      // Issue x4 on the cycle a buffered x4 is written: busy stays set.
      queueMdu(5'd4, 32'h44);
      applyStimulus(idle());
      s = idle(); s.issue_valid = 1'b1; s.issue_addr = 5'd4;
      applyStimulus(s);
      s = idle(); s.rs2 = 5'd4;
      applyStimulus(s);
      queueMdu(5'd4, 32'h45);
      applyStimulus(s); applyStimulus(s); applyStimulus(s);

      // WB to x0 and MDU result for x0: no write, nothing buffered.
      queueMdu(5'd0, 32'hFFFF_FFFF);
      s = idle(); s.wb_valid = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'h1234;
      s.rs1 = 5'd0; s.dst = 5'd0;
      applyStimulus(s);
      applyStimulus(idle());

      // Random traffic with occasional mid-run reset.
      for (int i = 0; i < 2000; i++) begin
         s.rst_n       = ($urandom_range(0, 299) != 0);
         s.wb_valid    = ($urandom_range(0, 1) == 1);
         s.wb_addr     = 5'($urandom_range(0, 7));
         s.wb_data     = $urandom;
         s.issue_valid = ($urandom_range(0, 3) == 0);
         s.issue_addr  = 5'($urandom_range(0, 7));
         s.rs1         = 5'($urandom_range(0, 7));
         s.rs2         = 5'($urandom_range(0, 7));
         s.dst         = 5'($urandom_range(0, 7));
         if (!pend_valid && $urandom_range(0, 2) == 0)
            queueMdu(5'($urandom_range(0, 7)), $urandom);
         applyStimulus(s);
      end

      // Drain everything still buffered, then confirm every predicted write appeared.
      for (int i = 0; i < 2 * DEPTH + 6; i++) applyStimulus(idle());
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("writes_outstanding", 32'(write_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
